// File: rtl/simd_wave_ctrl.sv
// rtl/simd_wave_ctrl.sv - per-wave fetch/decode/issue sequencer for a SIMD compute unit
// Optional watchdog: define SIMD_WAVE_CTRL_TIMEOUT_EN to add timeout_err and an 8-bit wait counter.
module simd_wave_ctrl #(
   parameter int WAVE_SIZE = 32,
   parameter int PC_W      = 8,
   parameter int INSTR_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 start,
   input  logic signed [31:0]   wave_id,
   input  logic signed [31:0]   block_id,
   input  logic [31:0]          block_dim,
   input  logic [31:0]          block_threads,
   output logic                 done,
   output logic                 busy,
   output logic                 fetch_valid,
   output logic [PC_W-1:0]      fetch_addr,
   input  logic                 instr_valid,
   input  logic [INSTR_W-1:0]   instr,
   output logic                 exec_valid,
   output logic [INSTR_W-1:0]   exec_instr,
   input  logic                 exec_done,
   output logic [WAVE_SIZE-1:0] lane_mask,
   output logic [31:0]          base_tid
`ifdef SIMD_WAVE_CTRL_TIMEOUT_EN
   ,
   output logic                 timeout_err
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [3:0] OP_RET = 4'hF;
   localparam logic [3:0] OP_JMP = 4'hE;

   state_t               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [WAVE_SIZE-1:0] mask_q, mask_d;
   logic [31:0]          tid_q, tid_d;

   logic [WAVE_SIZE-1:0] mask_calc;
   logic [31:0]          tid_calc;
   logic [63:0]          wave_first;
   logic [3:0]           opcode;

   assign opcode = instr_q[INSTR_W-1:INSTR_W-4];

   // Lane qualification is done in 64 bits so large wave_id * WAVE_SIZE cannot wrap into range.
   assign wave_first = 64'($unsigned(wave_id)) * 64'(WAVE_SIZE);
   assign tid_calc   = block_id * block_dim + wave_id * 32'(WAVE_SIZE);

   always_comb begin
      mask_calc = '0;
      for (int i = 0; i < WAVE_SIZE; i++) begin
         mask_calc[i] = (wave_first + 64'(i)) < {32'b0, block_threads};
      end
   end

`ifdef SIMD_WAVE_CTRL_TIMEOUT_EN
   logic [7:0] wait_q, wait_d;
   logic       err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      mask_d  = mask_q;
      tid_d   = tid_q;
      unique case (state_q)
         IDLE: begin
            if (start && !wave_id[31]) begin
               state_d = FETCH;
               pc_d    = '0;
               mask_d  = mask_calc;
               tid_d   = tid_calc;
            end
         end
         FETCH: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (opcode == OP_RET) begin
               state_d = DONE;
            end else if (opcode == OP_JMP) begin
               pc_d    = instr_q[PC_W-1:0];
               state_d = FETCH;
            end else if (mask_q == '0) begin
               // No live lanes: retire the instruction without issuing it.
               pc_d    = pc_q + PC_W'(1);
               state_d = FETCH;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (exec_done) begin
               pc_d    = pc_q + PC_W'(1);
               state_d = FETCH;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

`ifdef SIMD_WAVE_CTRL_TIMEOUT_EN
      err_d = err_q;
      if (((state_q == FETCH) && !instr_valid) || ((state_q == EXEC) && !exec_done)) begin
         // The increment that would reach 255 ends the wait instead.
         if (wait_q == 8'd254) begin
            state_d = DONE;
            err_d   = 1'b1;
         end
      end
      if (state_d != state_q) begin
         wait_d = '0;
      end else if ((state_q == FETCH) || (state_q == EXEC)) begin
         wait_d = wait_q + 8'd1;
      end else begin
         wait_d = wait_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         mask_q  <= '0;
         tid_q   <= '0;
`ifdef SIMD_WAVE_CTRL_TIMEOUT_EN
         wait_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else if (enable) begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         mask_q  <= mask_d;
         tid_q   <= tid_d;
`ifdef SIMD_WAVE_CTRL_TIMEOUT_EN
         wait_q  <= wait_d;
         err_q   <= err_d;
`endif
      end
   end

   assign done        = (state_q == DONE);
   assign busy        = (state_q == FETCH) || (state_q == DECODE) || (state_q == EXEC);
   assign fetch_valid = (state_q == FETCH);
   assign fetch_addr  = pc_q;
   assign exec_valid  = (state_q == EXEC);
   assign exec_instr  = instr_q;
   assign lane_mask   = mask_q;
   assign base_tid    = tid_q;
`ifdef SIMD_WAVE_CTRL_TIMEOUT_EN
   assign timeout_err = err_q;
`endif

endmodule

// File: tb/tb_simd_wave_ctrl.sv
// tb/tb_simd_wave_ctrl.sv - randomized self-checking bench for simd_wave_ctrl
module tb_simd_wave_ctrl;
   localparam int WS = 32;

   logic               clk = 1'b0;
   logic               rst, enable, start, instr_valid, exec_done;
   logic signed [31:0] wave_id, block_id;
   logic [31:0]        block_dim, block_threads;
   logic               done, busy, fetch_valid, exec_valid;
   logic [7:0]         fetch_addr;
   logic [15:0]        instr, exec_instr;
   logic [31:0]        lane_mask, base_tid;
`ifdef SIMD_WAVE_CTRL_TIMEOUT_EN
   logic               timeout_err;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [15:0] prog [256];
   int          addrq[$];
   int          exp_addrq[$];
   logic [15:0] exec_seen[$];
   logic [15:0] exp_execq[$];
   int          n_exec, n_done, done_cyc;
   logic [31:0] got_tid, got_mask;

   always #5 clk = ~clk;

   simd_wave_ctrl #(.WAVE_SIZE(WS), .PC_W(8), .INSTR_W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .start(start),
      .wave_id(wave_id), .block_id(block_id), .block_dim(block_dim),
      .block_threads(block_threads), .done(done), .busy(busy),
      .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
      .instr_valid(instr_valid), .instr(instr),
      .exec_valid(exec_valid), .exec_instr(exec_instr), .exec_done(exec_done),
      .lane_mask(lane_mask), .base_tid(base_tid)
`ifdef SIMD_WAVE_CTRL_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_tid(input logic [31:0] bid, input logic [31:0] dim,
                                           input logic [31:0] wid);
      return bid * dim + wid * 32'(WS);
   endfunction

   function automatic logic [31:0] exp_mask(input longint wid, input longint thr);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < WS; i++) if (wid * WS + i < thr) m[i] = 1'b1;
      return m;
   endfunction

   // Walk the program as the ISA defines it: RET ends, JMP redirects, anything else runs then steps.
   function automatic void model_prog(input bit active);
      int pc;
      logic [3:0] op;
      pc = 0;
      exp_addrq.delete();
      exp_execq.delete();
      for (int step = 0; step < 600; step++) begin
         exp_addrq.push_back(pc);
         op = prog[pc][15:12];
         if (op == 4'hF) return;
         if (op == 4'hE) pc = int'(prog[pc][7:0]);
         else begin
            if (active) exp_execq.push_back(prog[pc]);
            pc = (pc + 1) % 256;
         end
      end
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; instr_valid = 1'b0; exec_done = 1'b0; enable = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_wave(input logic signed [31:0] wid, input logic signed [31:0] bid,
                           input logic [31:0] dim, input logic [31:0] thr,
                           input int lf, input int le, input bit mid_start, input bit noise);
      int fw, ew, end_at;
      bit pfv, pev;
      addrq.delete(); exec_seen.delete();
      n_exec = 0; n_done = 0; done_cyc = -1;
      fw = 0; ew = 0; pfv = 0; pev = 0; end_at = 3000;
      @(negedge clk);
      wave_id = wid; block_id = bid; block_dim = dim; block_threads = thr; start = 1'b1;
      @(negedge clk);
      got_tid = base_tid; got_mask = lane_mask;
      for (int cyc = 0; cyc < end_at; cyc++) begin
         instr_valid = 1'b0; exec_done = 1'b0; start = 1'b0;
         if (fetch_valid) begin
            if (!pfv) begin addrq.push_back(int'(fetch_addr)); fw = 0; end
            if (fw >= lf) begin instr_valid = 1'b1; instr = prog[fetch_addr]; end
            fw++;
         end else if (noise) begin
            instr_valid = 1'($urandom_range(0, 1)); instr = 16'hF000;
         end
         if (exec_valid) begin
            if (!pev) begin n_exec++; exec_seen.push_back(exec_instr); ew = 0; end
            if (ew >= le) exec_done = 1'b1;
            ew++;
         end else if (noise) begin
            exec_done = 1'($urandom_range(0, 1));
         end
         if (mid_start && cyc == 2) begin
            start = 1'b1; wave_id = 5; block_id = 9; block_threads = 1000;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) begin done_cyc = cyc; end_at = cyc + 4; end
         end
         pfv = fetch_valid; pev = exec_valid;
         @(negedge clk);
      end
      instr_valid = 1'b0; exec_done = 1'b0; start = 1'b0;
   endtask

   task automatic wave_and_check(input string tag, input logic signed [31:0] wid,
                                 input logic signed [31:0] bid, input logic [31:0] dim,
                                 input logic [31:0] thr, input int lf, input int le,
                                 input bit mid_start, input bit noise);
      logic [31:0] em;
      em = exp_mask(longint'(wid), longint'(thr));
      model_prog(em != 0);
      run_wave(wid, bid, dim, thr, lf, le, mid_start, noise);
      check({tag, "_tid"}, got_tid, exp_tid(bid, dim, wid));
      check({tag, "_mask"}, got_mask, em);
      check({tag, "_tid_end"}, base_tid, exp_tid(bid, dim, wid));
      check({tag, "_naddr"}, addrq.size(), exp_addrq.size());
      for (int i = 0; i < addrq.size() && i < exp_addrq.size(); i++)
         check({tag, "_addr"}, addrq[i], exp_addrq[i]);
      check({tag, "_nexec"}, n_exec, exp_execq.size());
      for (int i = 0; i < exec_seen.size() && i < exp_execq.size(); i++)
         check({tag, "_einstr"}, exec_seen[i], exp_execq[i]);
      check({tag, "_ndone"}, n_done, 1);
      check({tag, "_busy_after"}, busy, 1'b0);
   endtask

   initial begin
      int n, j, found;
      logic [31:0] dim, thr;
      rst = 1'b1; enable = 1'b1; start = 1'b0; instr_valid = 1'b0; exec_done = 1'b0;
      instr = '0; wave_id = 0; block_id = 0; block_dim = 0; block_threads = 0;
      repeat (2) @(negedge clk);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_fv", fetch_valid, 0);
      check("rst_ev", exec_valid, 0);
      check("rst_faddr", fetch_addr, 0);
      check("rst_einstr", exec_instr, 0);
      check("rst_mask", lane_mask, 0);
      check("rst_tid", base_tid, 0);
`ifdef SIMD_WAVE_CTRL_TIMEOUT_EN
      check("rst_terr", timeout_err, 0);
`endif
      rst = 1'b0;

      clear_prog();
      prog[0] = 16'h1000; prog[1] = 16'h2000; prog[2] = 16'hF000;
      wave_and_check("full", 1, 2, 64, 64, 1, 2, 0, 0);
      check("full_tid160", got_tid, 32'd160);
      check("full_mask_ones", got_mask, 32'hFFFF_FFFF);
      check("full_2exec", n_exec, 2);

      wave_and_check("part40", 1, 2, 64, 40, 0, 2, 0, 0);
      check("part40_mask", got_mask, 32'h0000_00FF);
      wave_and_check("empty32", 1, 2, 64, 32, 0, 2, 0, 0);
      check("empty32_mask", got_mask, 32'h0);
      check("empty32_noexec", n_exec, 0);

      clear_prog();
      prog[0] = 16'hE003;
      prog[1] = 16'h1000;
      wave_and_check("jmp", 0, 0, 32, 32, 2, 1, 0, 0);
      check("jmp_addr_seq", (addrq.size() == 2) ? {addrq[0][7:0], addrq[1][7:0]} : 16'hFFFF, 16'h0003);

      clear_prog();
      wave_and_check("lat", 0, 3, 32, 32, 0, 0, 0, 0);
      check("lat_done_cyc", done_cyc, 2);

      // Invalid wave id in IDLE must not start a wave.
      @(negedge clk);
      wave_id = -1; block_id = 50; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("neg_busy", busy, 0);
      check("neg_fv", fetch_valid, 0);
      check("neg_tid", base_tid, exp_tid(3, 32, 0));

      clear_prog();
      for (int i = 0; i < 5; i++) prog[i] = 16'h3000 + 16'(i);
      wave_and_check("midstart", 2, 4, 128, 100, 1, 1, 1, 0);

      // Enable low freezes the FETCH state and ignores instr_valid and start.
      clear_prog();
      @(negedge clk);
      wave_id = 0; block_id = 6; block_dim = 32; block_threads = 32; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got_tid = base_tid;
      enable = 1'b0; instr_valid = 1'b1; instr = 16'hF000; start = 1'b1; wave_id = 3; block_id = 77;
      repeat (3) @(negedge clk);
      check("hold_fv", fetch_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_faddr", fetch_addr, 0);
      check("hold_tid", base_tid, got_tid);
      enable = 1'b1; start = 1'b0;
      @(negedge clk);
      instr_valid = 1'b0;
      check("resume_decode_fv", fetch_valid, 0);
      check("resume_busy", busy, 1);
      @(negedge clk);
      check("resume_done", done, 1);
      check("resume_done_busy", busy, 0);
      @(negedge clk);
      check("resume_idle", done, 0);

      // Reset mid-EXEC abandons the wave.
      prog[0] = 16'h1000;
      @(negedge clk);
      wave_id = 0; block_id = 1; block_dim = 32; block_threads = 32; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
         instr_valid = fetch_valid; instr = prog[fetch_addr];
         if (exec_valid) found = 1;
         else @(negedge clk);
      end
      instr_valid = 1'b0;
      check("rstx_reached_exec", found, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstx_busy", busy, 0);
      check("rstx_ev", exec_valid, 0);
      check("rstx_fv", fetch_valid, 0);
      check("rstx_done", done, 0);
      check("rstx_outs", {fetch_addr, exec_instr, lane_mask, base_tid}, 0);
      found = 0;
      repeat (4) begin @(negedge clk); if (done || busy) found = 1; end
      check("rstx_no_done", found, 0);

      for (int t = 0; t < 20; t++) begin
         clear_prog();
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) prog[i] = {4'($urandom_range(0, 13)), 12'($urandom)};
         if ($urandom_range(0, 1) == 1) begin
            j = $urandom_range(0, n - 1);
            prog[j] = {8'hE0, 8'($urandom_range(j + 1, n))};
         end
         dim = $urandom_range(1, 300);
         thr = $urandom_range(0, dim);
         wave_and_check("rand", $urandom_range(0, 9), $urandom_range(0, 1000), dim, thr,
                        $urandom_range(0, 4), $urandom_range(0, 4), 0, 1);
      end

`ifdef SIMD_WAVE_CTRL_TIMEOUT_EN
      do_reset();
      @(negedge clk);
      wave_id = 0; block_id = 0; block_dim = 32; block_threads = 32; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0; found = 0;
      for (int c = 0; c < 600 && found == 0; c++) begin
         if (done) found = 1;
         else begin
            if (fetch_valid) n++;
            @(negedge clk);
         end
      end
      check("to_done", found, 1);
      check("to_fetch_cycles", n, 255);
      check("to_err", timeout_err, 1);
      repeat (2) @(negedge clk);
      check("to_err_sticky", timeout_err, 1);
      do_reset();
      check("to_err_clr", timeout_err, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
